// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch stage.
// Provides a zero-latency fetch path, branch/jump redirect with IF/ID flush,
// a hazard-unit stall, and single-level interrupt entry/return through EPC.
// Optional macro INT_PENDING_LATCH_EN: when defined, interrupt requests are held
// in a pending flop until they are accepted. When undefined, INT_req is
// level-sensitive, and a request that drops before it is accepted is lost.

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        INT_req,
    input  logic        eret,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_PC_out,
    output logic        IF_Flush,
    output logic        INT_detected,
    output logic        INT_restore,
    output logic [31:0] EPC
);

    localparam int unsigned XLEN = 32;
    // Fetch addresses are always word aligned.
    localparam logic [XLEN-1:0] PC_MASK = 32'hFFFF_FFFC;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HANDLER = 1'b1
    } state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   pc_sel;
    logic [XLEN-1:0]   pc_d;
    logic              pending;
    logic              int_accept;
    logic              eret_accept;
    logic              redirect;

    // Interrupt pending source: latched flop or raw level.
`ifdef INT_PENDING_LATCH_EN
    logic pend_q;

    // Capture a request in any state; only an accept or reset consumes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else if (int_accept) begin
            pend_q <= 1'b0;
        end else if (INT_req) begin
            pend_q <= 1'b1;
        end
    end

    assign pending = INT_req | pend_q;
`else
    assign pending = INT_req;
`endif

    // Event qualification. A redirect or stall defers the interrupt. Reset masks all strobes.
    always_comb begin
        int_accept  = 1'b0;
        eret_accept = 1'b0;
        redirect    = 1'b0;
        if (!reset) begin
            int_accept  = (state_q == ST_RUN) && pending && PCWrite
                          && !branch_taken && !jump;
            eret_accept = (state_q == ST_HANDLER) && eret && PCWrite;
            redirect    = (branch_taken || jump) && !eret_accept;
        end
    end

    // Next-PC selection in priority order, then forced to word alignment.
    always_comb begin
        pc_sel = pc_q + XLEN'(4);
        if (int_accept) begin
            pc_sel = INT_VECTOR;
        end else if (eret_accept) begin
            pc_sel = epc_q;
        end else if (branch_taken) begin
            pc_sel = branch_target;
        end else if (jump) begin
            pc_sel = jump_target;
        end else if (!PCWrite) begin
            pc_sel = pc_q;
        end
        pc_d = pc_sel & PC_MASK;
    end

    // Run/handler FSM with the PC and EPC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC & PC_MASK;
            epc_q   <= '0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                ST_RUN: begin
                    if (int_accept) begin
                        epc_q   <= pc_q;
                        state_q <= ST_HANDLER;
                    end
                end
                ST_HANDLER: begin
                    if (eret_accept) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Zero-latency fetch path and event strobes.
    assign imem_addr    = pc_q;
    assign IF_PC_out    = pc_q;
    assign IF_inst      = imem_rdata;
    assign IF_Flush     = redirect;
    assign INT_detected = int_accept;
    assign INT_restore  = eret_accept;
    assign EPC          = epc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with default parameters (RESET_PC=0, INT_VECTOR=0x800).
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        PCWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        INT_req;
    logic        eret;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] IF_inst;
    logic [31:0] IF_PC_out;
    logic        IF_Flush;
    logic        INT_detected;
    logic        INT_restore;
    logic [31:0] EPC;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] INST_KEY = 32'hDEAD_BEEF;

    pc_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .INT_req       (INT_req),
        .eret          (eret),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .IF_inst       (IF_inst),
        .IF_PC_out     (IF_PC_out),
        .IF_Flush      (IF_Flush),
        .INT_detected  (INT_detected),
        .INT_restore   (INT_restore),
        .EPC           (EPC)
    );

    // Instruction memory model: the contents are derived from the address.
    assign imem_rdata = imem_addr ^ INST_KEY;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp);
        chk({tag, ".addr"}, imem_addr, exp);
        chk({tag, ".ifpc"}, IF_PC_out, exp);
        chk({tag, ".inst"}, IF_inst, exp ^ INST_KEY);
    endtask

    task automatic chk_strobes(input string tag, input logic fl, input logic det, input logic rst);
        chk({tag, ".flush"}, 32'(IF_Flush), 32'(fl));
        chk({tag, ".det"},   32'(INT_detected), 32'(det));
        chk({tag, ".rest"},  32'(INT_restore), 32'(rst));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; PCWrite = 1'b1; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; INT_req = 1'b1; eret = 1'b0;
        #1;
        // Reset asserted: strobes masked even with a request present.
        chk_pc("rst", 32'h0);
        chk_strobes("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.epc", EPC, 32'h0);
        INT_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_pc("rel0", 32'h0);

        // Sequential fetch from reset.
        tick(); chk_pc("seq4", 32'h4);
        tick(); chk_pc("seq8", 32'h8);
        tick(); chk_pc("seqC", 32'hC);
        tick(); chk_pc("seq10", 32'h10);

        // Two stall cycles, then resume.
        PCWrite = 1'b0; #1;
        chk_strobes("stall0", 1'b0, 1'b0, 1'b0);
        tick(); chk_pc("stall1", 32'h10); chk("stall1.flush", 32'(IF_Flush), 32'h0);
        tick(); chk_pc("stall2", 32'h10);
        PCWrite = 1'b1;
        tick(); chk_pc("resume", 32'h14);
        tick(); tick(); tick(); chk_pc("at20", 32'h20);

        // Branch beats jump, target low bits ignored.
        branch_taken = 1'b1; branch_target = 32'h103; jump = 1'b1; jump_target = 32'h200; #1;
        chk_strobes("brj", 1'b1, 1'b0, 1'b0);
        tick();
        branch_taken = 1'b0; jump = 1'b0; #1;
        chk_pc("brj.pc", 32'h100);
        chk("brj.noflush", 32'(IF_Flush), 32'h0);

        // Jump during a stall still redirects and flushes.
        PCWrite = 1'b0; jump = 1'b1; jump_target = 32'h41; #1;
        chk("jstall.flush", 32'(IF_Flush), 32'h1);
        tick();
        PCWrite = 1'b1; jump = 1'b0; #1;
        chk_pc("jstall.pc", 32'h40);

        // Interrupt entry at 0x40.
        INT_req = 1'b1; #1;
        chk_strobes("int", 1'b0, 1'b1, 1'b0);
        tick();
        INT_req = 1'b0; #1;
        chk_pc("int.vec", 32'h800);
        chk("int.epc", EPC, 32'h40);
        chk_strobes("int.after", 1'b0, 1'b0, 1'b0);
        tick(); chk_pc("hnd4", 32'h804);

        // Stalled eret is ignored.
        eret = 1'b1; PCWrite = 1'b0; #1;
        chk("eret_stall.rest", 32'(INT_restore), 32'h0);
        tick(); chk_pc("eret_stall.pc", 32'h804);

        // eret beats a simultaneous branch and suppresses the flush.
        PCWrite = 1'b1; branch_taken = 1'b1; branch_target = 32'h300; #1;
        chk_strobes("eret", 1'b0, 1'b0, 1'b1);
        tick();
        branch_taken = 1'b0; #1;
        chk_pc("eret.pc", 32'h40);
        chk("eret.epc", EPC, 32'h40);
        // eret while in RUN is a no-op.
        chk("eret_run.rest", 32'(INT_restore), 32'h0);
        tick();
        eret = 1'b0; #1;
        chk_pc("eret_run.pc", 32'h44);

        // Request pulse coincides with a branch, so the interrupt is deferred.
        INT_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h120; #1;
        chk_strobes("defer", 1'b1, 1'b0, 1'b0);
        tick();
        INT_req = 1'b0; branch_taken = 1'b0; #1;
        chk_pc("defer.pc", 32'h120);
`ifdef INT_PENDING_LATCH_EN
        chk("defer.det", 32'(INT_detected), 32'h1);
        tick();
        chk_pc("defer.vec", 32'h800);
        chk("defer.epc", EPC, 32'h120);
`else
        chk("defer.det", 32'(INT_detected), 32'h0);
        tick();
        chk_pc("defer.lost", 32'h124);
        chk("defer.epc", EPC, 32'h40);
        INT_req = 1'b1; #1;
        chk("int2.det", 32'(INT_detected), 32'h1);
        tick();
        INT_req = 1'b0; #1;
        chk_pc("int2.vec", 32'h800);
        chk("int2.epc", EPC, 32'h124);
`endif
        tick(); tick(); chk_pc("hnd8", 32'h808);

        // Asynchronous reset in the handler, with eret pending.
        eret = 1'b1; reset = 1'b1; #1;
        chk_pc("hrst", 32'h0);
        chk("hrst.epc", EPC, 32'h0);
        chk_strobes("hrst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0; #1;
        // The FSM is back in RUN, so eret is not accepted.
        chk("hrst.rest", 32'(INT_restore), 32'h0);
        tick();
        eret = 1'b0; #1;
        chk_pc("hrst.seq", 32'h4);

        // PC increment wraps modulo 2^32.
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        tick();
        jump = 1'b0; #1;
        chk_pc("wrap.top", 32'hFFFF_FFFC);
        tick(); chk_pc("wrap.zero", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Bound on total simulation time.
    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter INT_VECTOR, default 32'h0000_0800, interrupt handler entry address.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port PCWrite  in  1  hazard-unit enable; 0 = stall (hold PC).
REQ-006 SHALL have port branch_taken  in  1  branch resolved taken.
REQ-007 SHALL have port branch_target  in  32  branch destination.
REQ-008 SHALL have port jump  in  1  jump decoded.
REQ-009 SHALL have port jump_target  in  32  jump destination.
REQ-010 SHALL have port INT_req  in  1  external interrupt request.
REQ-011 SHALL have port eret  in  1  return-from-interrupt decoded.
REQ-012 SHALL have port imem_rdata  in  32  instruction memory read data (combinational).
REQ-013 SHALL have port imem_addr  out  32  instruction memory address.
REQ-014 SHALL have port IF_inst  out  32  fetched instruction to IF/ID register.
REQ-015 SHALL have port IF_PC_out  out  32  address of IF_inst.
REQ-016 SHALL have port IF_Flush  out  1  squash IF/ID contents.
REQ-017 SHALL have ports INT_detected / INT_restore  out  1 each  one-cycle interrupt entry / return strobes to IF/ID register.
REQ-018 SHALL have port EPC  out  32  saved resume address.

Function
REQ-019 SHALL drive imem_addr = IF_PC_out = PC, IF_inst = imem_rdata, combinationally; zero fetch latency.
REQ-020 SHALL force PC[1:0] = 2'b00; targets' low two bits ignored.
REQ-021 SHALL implement FSM states RUN and HANDLER; reset state RUN.
REQ-022 SHALL select next PC by priority: interrupt accept > eret accept > branch_taken (branch_target) > jump (jump_target) > PCWrite=0 (hold) > PC+4, wrapping modulo 2^32.
REQ-023 SHALL assert IF_Flush combinationally in any cycle branch_taken or jump redirects PC, in either state, regardless of PCWrite.
REQ-024 SHALL accept interrupt when state=RUN, pending=1, PCWrite=1, branch_taken=0, jump=0; otherwise defer, keeping request pending.
REQ-025 SHALL, on accept: assert INT_detected that cycle; at edge load EPC<=PC, PC<=INT_VECTOR, clear pending, state<=HANDLER.
REQ-026 SHALL ignore INT_req sampling in HANDLER (no nesting) except as per REQ-036.
REQ-027 SHALL accept eret when state=HANDLER and PCWrite=1: assert INT_restore that cycle; at edge PC<=EPC, state<=RUN; accept takes priority over simultaneous branch/jump and suppresses IF_Flush.
REQ-028 SHALL treat eret in RUN, or with PCWrite=0, as no-op.
REQ-029 SHALL never assert INT_detected and INT_restore in the same cycle.
REQ-030 SHALL hold EPC stable except at interrupt accept.

Reset
REQ-031 SHALL on reset, asynchronously: PC=RESET_PC, EPC=0, pending=0, state=RUN.
REQ-032 SHALL with reset asserted drive IF_Flush=0, INT_detected=0, INT_restore=0, imem_addr=RESET_PC.
REQ-033 SHALL abandon a handler on reset mid-HANDLER; no INT_restore issued.

Configuration
REQ-034 SHALL gate pending-request latching with macro INT_PENDING_LATCH_EN.
REQ-035 SHALL, without INT_PENDING_LATCH_EN, use pending = INT_req (level, unlatched); request dropped before accept is lost.
REQ-036 SHALL, with INT_PENDING_LATCH_EN, set a pending flop on any cycle INT_req=1 (any state, including HANDLER and stalls), cleared only at accept or reset; a request during HANDLER is taken in RUN after return.

Verification
REQ-037 SHALL cover: reset release, PCWrite=1, no events -> imem_addr 0x0,0x4,0x8,0xC on successive cycles.
REQ-038 SHALL cover: PC=0x10, PCWrite=0 two cycles -> PC holds 0x10, IF_Flush=0; then 0x14.
REQ-039 SHALL cover: PC=0x20, branch_taken=1 target 0x103, jump=1 target 0x200 same cycle -> IF_Flush=1, next PC 0x100.
REQ-040 SHALL cover: PC=0x40, INT_req=1 -> INT_detected=1 one cycle, EPC=0x40, PC=0x800; later eret -> INT_restore=1 one cycle, PC=0x40.
REQ-041 SHALL cover: INT_req one-cycle pulse coincident with branch_taken -> with macro, interrupt taken next cycle, EPC=branch target; without macro, no interrupt.
REQ-042 SHALL cover: reset asserted while in HANDLER at PC=0x808 -> PC=0x0, EPC=0, state RUN, no strobes.
